// File: rtl/vic_responder.sv
// Vectored-interrupt responder for one bus priority level: merges device requests
// into irq_o and answers the CPU strobe with the winning vector and a device grant.
module vic_responder #(
   parameter int              N            = 4,
   parameter logic [N*9-1:0]  VECTORS      = {9'o074, 9'o070, 9'o064, 9'o060},
   parameter logic [8:0]      SPURIOUS_VEC = 9'o000
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_n,
   input  logic [N-1:0] dev_req,
   output logic [N-1:0] dev_ack,
   output logic         irq_o,
   input  logic         istb_i,
   output logic [8:0]   ivec_o,
   output logic         iack_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           irq_q, irq_d;
   logic           iack_q, iack_d;
   logic [8:0]     ivec_q, ivec_d;
   logic [N-1:0]   dev_ack_q, dev_ack_d;

   logic [N-1:0]   grant_s;
   logic [8:0]     vec_s;
   logic           valid_s;

   // Fixed-priority encoder: scanning from the top down lets index 0 win last.
   always_comb begin
      grant_s = '0;
      vec_s   = SPURIOUS_VEC;
      valid_s = |dev_req;
      for (int i = N - 1; i >= 0; i--) begin
         grant_s = dev_req[i] ? (N'(1'b1) << i) : grant_s;
         vec_s   = dev_req[i] ? VECTORS[9*i +: 9] : vec_s;
      end
   end

   // Next-state and next-output logic; the ACK-cycle outputs are loaded on the strobe edge.
   always_comb begin
      state_d   = state_q;
      irq_d     = 1'b0;
      iack_d    = 1'b0;
      ivec_d    = 9'o000;
      dev_ack_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (istb_i) begin
               state_d   = ST_ACK;
               iack_d    = 1'b1;
               ivec_d    = vec_s;
               dev_ack_d = grant_s;
            end else begin
               irq_d     = valid_s;
            end
         end
         ST_ACK: begin
            state_d = ST_DROP;
         end
         ST_DROP: begin
            if (istb_i) begin
               state_d = ST_DROP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; dev_ack_q doubles as the latched winner.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q   <= ST_IDLE;
         irq_q     <= 1'b0;
         iack_q    <= 1'b0;
         ivec_q    <= 9'o000;
         dev_ack_q <= '0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         iack_q    <= iack_d;
         ivec_q    <= ivec_d;
         dev_ack_q <= dev_ack_d;
      end
   end

   assign irq_o   = irq_q;
   assign iack_o  = iack_q;
   assign ivec_o  = ivec_q;
   assign dev_ack = dev_ack_q;

endmodule

// File: tb/tb_vic_responder.sv
// Scoreboard bench for vic_responder: stimulus pushes expected acknowledges,
// a negedge monitor pops and compares them whenever iack_o is seen.
module tb_vic_responder;

   logic         wb_clk_i = 1'b0;
   logic         wb_rst_n = 1'b0;
   logic [3:0]   dev_req  = 4'b0000;
   logic [3:0]   dev_ack;
   logic         irq_o;
   logic         istb_i   = 1'b0;
   logic [8:0]   ivec_o;
   logic         iack_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [8:0] vec;
      logic [3:0] ack;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [8:0] VEC_TAB [4] = '{9'o060, 9'o064, 9'o070, 9'o074};

   vic_responder dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_n (wb_rst_n),
      .dev_req  (dev_req),
      .dev_ack  (dev_ack),
      .irq_o    (irq_o),
      .istb_i   (istb_i),
      .ivec_o   (ivec_o),
      .iack_o   (iack_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: the lowest-numbered asserted request wins; none means spurious vector.
   function automatic exp_t model(input logic [3:0] req, input int c);
      exp_t e;
      e.vec = 9'o000;
      e.ack = 4'b0000;
      e.cyc = c;
      for (int i = 0; i < 4; i++) begin
         if (req[i]) begin
            e.vec = VEC_TAB[i];
            e.ack = 4'(1 << i);
            break;
         end
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Monitor: every acknowledge must match the oldest expectation; otherwise the bus is quiet.
   always @(negedge wb_clk_i) begin
      if (wb_rst_n) begin
         if (iack_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_iack", 32'(exp_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ivec", 32'(ivec_o), 32'(e.vec));
               chk("dev_ack", 32'(dev_ack), 32'(e.ack));
               chk("iack_latency", 32'(cyc), 32'(e.cyc));
            end
         end else begin
            chk("ivec_quiet", 32'(ivec_o), 32'd0);
            chk("dev_ack_quiet", 32'(dev_ack), 32'd0);
         end
      end
   end

   // One full handshake: strobe with req, device drops its grant, late requests join, strobe held.
   task automatic hs(input logic [3:0] req, input logic [3:0] late, input int hold);
      exp_t e;
      dev_req = req;
      istb_i  = 1'b1;
      e = model(req, cyc + 1);
      exp_q.push_back(e);
      tick();
      dev_req = (dev_req & ~e.ack) | late;
      tick();
      chk("iack_consumed", 32'(exp_q.size()), 32'd0);
      chk("irq_in_drop", 32'(irq_o), 32'd0);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("irq_held_strobe", 32'(irq_o), 32'd0);
      end
      istb_i = 1'b0;
      tick();
      tick();
      chk("irq_resample", 32'(irq_o), 32'(|dev_req));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      logic [3:0] r2;
      logic [3:0] lt;
      int         w;

      // Reset and idle
      repeat (3) tick();
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_iack", 32'(iack_o), 32'd0);
      chk("rst_ivec", 32'(ivec_o), 32'd0);
      chk("rst_dev_ack", 32'(dev_ack), 32'd0);
      wb_rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_irq", 32'(irq_o), 32'd0);
      end

      // Single request
      dev_req = 4'b0100;
      tick();
      chk("single_irq", 32'(irq_o), 32'd1);
      hs(4'b0100, 4'b0000, 1);

      // Priority, then the remaining requester
      dev_req = 4'b1010;
      tick();
      chk("prio_irq", 32'(irq_o), 32'd1);
      hs(4'b1010, 4'b0000, 1);
      hs(4'b1000, 4'b0000, 0);

      // Spurious: request withdrawn as the strobe rises
      dev_req = 4'b0001;
      tick();
      chk("spur_irq", 32'(irq_o), 32'd1);
      hs(4'b0000, 4'b0000, 1);

      // Held strobe with a new request arriving during DROP
      dev_req = 4'b0001;
      tick();
      hs(4'b0001, 4'b1000, 20);
      hs(4'b1000, 4'b0000, 0);

      // Reset during the ACK cycle
      dev_req = 4'b0100;
      tick();
      istb_i = 1'b1;
      tick();
      chk("ack_before_rst", 32'(iack_o), 32'd1);
      wb_rst_n = 1'b0;
      #1;
      chk("rst_async_iack", 32'(iack_o), 32'd0);
      chk("rst_async_ivec", 32'(ivec_o), 32'd0);
      chk("rst_async_dev_ack", 32'(dev_ack), 32'd0);
      istb_i = 1'b0;
      tick();
      tick();
      wb_rst_n = 1'b1;
      tick();
      chk("post_rst_irq", 32'(irq_o), 32'd1);
      dev_req = 4'b0000;
      tick();
      tick();

      // Randomized handshakes
      for (int it = 0; it < 150; it++) begin
         r = 4'($urandom_range(0, 15));
         dev_req = r;
         w = $urandom_range(1, 3);
         repeat (w) tick();
         chk("rand_irq", 32'(irq_o), 32'(|r));
         r2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : r;
         lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         hs(r2, lt, $urandom_range(0, 4));
      end

      dev_req = 4'b0000;
      tick();
      tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vic_responder.md
Name: vic_responder

Overview:
- Peripheral-side responder for the CPU board's vectored-interrupt handshake at one bus priority level (BR4 or BR5).
- Collects level-sensitive requests from up to N devices and presents one combined request line to the CPU.
- When the CPU issues its interrupt strobe, selects the highest-priority pending source, returns its 9-bit vector with a one-cycle acknowledge, and sends that source a one-cycle grant pulse.
- One instance per level, between the device controllers and the CPU board's irq_i/istb_o/ivec/iack_i pins.

Parameters:
- N, 4, number of request sources (1..8); index 0 has the highest priority.
- VECTORS, {9'o074,9'o070,9'o064,9'o060}, packed N*9-bit vector table; source i uses bits [9i+8:9i].
- SPURIOUS_VEC, 9'o000, vector returned when a strobe arrives with no request pending.

Ports:
- wb_clk_i  in  1  system clock; all logic runs on the rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- dev_req  in  N  level requests from devices; a device holds its bit until it receives dev_ack.
- dev_ack  out  N  one-cycle grant pulse to the selected source.
- irq_o  out  1  combined request to the CPU's irq_i for this level.
- istb_i  in  1  CPU interrupt strobe for this level; held high until iack_o is seen.
- ivec_o  out  9  vector bus; zero whenever iack_o is low, because vector buses from several responders are ORed together.
- iack_o  out  1  one-cycle vector-valid acknowledge to the CPU.

Behaviour:
- Reset (wb_rst_n low, asynchronous): state IDLE; irq_o=0, iack_o=0, ivec_o=0, dev_ack=0, winner register=0. Releasing reset during a handshake leaves the block in IDLE with no acknowledge issued.
- All outputs are registered.
- State IDLE:
  - irq_o <= |dev_req, registered, so irq_o follows dev_req with 1-cycle latency.
  - If istb_i=1: latch win = lowest index i with dev_req[i]=1, plus a valid flag valid=|dev_req, both sampled in this same cycle. Go to ACK. Force irq_o <= 0.
- State ACK (exactly one cycle):
  - iack_o=1.
  - If valid=1: ivec_o = VECTORS[win], dev_ack[win]=1.
  - If valid=0: ivec_o = SPURIOUS_VEC, dev_ack=0.
  - Go to DROP.
  - Latency: strobe sampled in cycle T gives iack_o high in cycle T+1.
- State DROP:
  - iack_o=0, ivec_o=0, dev_ack=0, irq_o=0.
  - Stay while istb_i=1. When istb_i=0, go to IDLE; irq_o is re-sampled from dev_req one cycle later.
  - Devices must drop dev_req within 2 cycles of dev_ack. A request still asserted when the block returns to IDLE is treated as a new request.
- Arbitration: fixed priority with no rotation. Requests that arrive after the strobe-sampling cycle are not considered for that handshake.
- Request withdrawn between irq_o assertion and the strobe: the spurious path applies; the CPU still receives iack_o, and no dev_ack is pulsed.
- A strobe already high on entry to IDLE (CPU holding it across consecutive interrupts) starts a new handshake immediately.
- Vectors are passed through unmodified; bits [1:0] are the caller's responsibility and are 0 in the default table.
- N=1 is legal: the priority encoder degenerates to a single request/grant pair.

Test Plan:
- Reset then idle: wb_rst_n=0 → all outputs 0. Release, dev_req=0 for 10 cycles → irq_o stays 0.
- Single request: dev_req=4'b0100 → irq_o=1 the next cycle. Raise istb_i at cycle T → at T+1 iack_o=1, ivec_o=9'o070, dev_ack=4'b0100. Device drops its request, CPU drops istb_i → irq_o=0, state IDLE.
- Priority: dev_req=4'b1010, strobe → ivec_o=9'o064, dev_ack[1]=1. Requester 1 drops; after istb_i falls, irq_o=1 again. Second strobe → ivec_o=9'o074, dev_ack[3]=1.
- Spurious: dev_req=4'b0001 deasserted in the same cycle istb_i rises → iack_o=1 with ivec_o=9'o000, dev_ack=0.
- Held strobe: istb_i kept high for 20 cycles after iack_o → only one iack_o pulse, irq_o=0 throughout. ivec_o=0 on every cycle where iack_o=0, checked across all tests.
- Reset mid-handshake: assert wb_rst_n=0 in the ACK cycle → iack_o, ivec_o and dev_ack drop immediately without waiting for a clock edge. After release with dev_req still set → irq_o=1 one cycle later.
